// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/load-store ports, the arbiter and memory.
// slave is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            if_kill;

  logic            ls_req;
  logic            ls_we;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wstrb;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    input  ls_req, ls_we, ls_addr,
    input  ls_wdata, ls_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, if_kill,
    output ls_req, ls_we, ls_addr,
    output ls_wdata, ls_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store.
// One transaction in flight; round-robin on ties.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  state_e state;
  owner_e owner;
  owner_e last_owner;
  logic   kill;

  logic tie;
  logic only_if;
  logic only_ls;
  logic pick_if;
  logic pick_ls;
  logic kill_hit;
  logic rsp;
  logic if_rv;
  logic ls_rv;

  logic            nxt_we;
  logic [AW-1:0]   nxt_addr;
  logic [DW-1:0]   nxt_wdata;
  logic [DW/8-1:0] nxt_wstrb;

  // pick at most one requester, only while idle and out of reset
  always_comb begin
    tie     = bus.if_req & bus.ls_req;
    only_if = bus.if_req & ~bus.ls_req;
    only_ls = bus.ls_req & ~bus.if_req;
    pick_if = 1'b0;
    pick_ls = 1'b0;
    if (rst_n && state == IDLE) begin
      unique case (1'b1)
        tie: begin
          pick_ls = (last_owner == OWN_IF);
          pick_if = (last_owner == OWN_LS);
        end
        only_if: pick_if = 1'b1;
        only_ls: pick_ls = 1'b1;
        default: ;
      endcase
    end
  end

  // payload to latch on accept; fetches carry no write data
  always_comb begin
    nxt_we    = 1'b0;
    nxt_addr  = bus.if_addr;
    nxt_wdata = '0;
    nxt_wstrb = '0;
    if (pick_ls) begin
      nxt_we    = bus.ls_we;
      nxt_addr  = bus.ls_addr;
      nxt_wdata = bus.ls_wdata;
      nxt_wstrb = bus.ls_wstrb;
    end
  end

  // route the response to its owner; a killed fetch is dropped
  always_comb begin
    kill_hit = bus.if_kill & (owner == OWN_IF)
             & (state != IDLE);
    rsp      = rst_n & (state == WAIT_RSP)
             & bus.mem_rvalid;
    if_rv    = rsp & (owner == OWN_IF)
             & ~kill & ~kill_hit;
    ls_rv    = rsp & (owner == OWN_LS);
  end

  assign bus.if_gnt    = pick_if;
  assign bus.ls_gnt    = pick_ls;
  assign bus.if_rvalid = if_rv;
  assign bus.ls_rvalid = ls_rv;
  assign bus.if_rdata  = if_rv ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = ls_rv ? bus.mem_rdata : '0;

  // transaction FSM with registered memory-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      last_owner    <= OWN_IF;
      kill          <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          kill <= 1'b0;
          if (pick_if || pick_ls) begin
            state         <= WAIT_GNT;
            owner         <= pick_ls ? OWN_LS : OWN_IF;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= nxt_we;
            bus.mem_addr  <= nxt_addr;
            bus.mem_wdata <= nxt_wdata;
            bus.mem_wstrb <= nxt_wstrb;
          end
        end
        WAIT_GNT: begin
          if (kill_hit) kill <= 1'b1;
          if (bus.mem_gnt) begin
            state       <= WAIT_RSP;
            bus.mem_req <= 1'b0;
          end
        end
        WAIT_RSP: begin
          if (kill_hit) kill <= 1'b1;
          if (bus.mem_rvalid) begin
            state      <= IDLE;
            last_owner <= owner;
            kill       <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule
